// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and register-index types for the datapath
package reg_file_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int REG_COUNT  = 1 << ADDR_WIDTH;

    // Register index as carried by decoded instructions
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // True when a read index hits the register being written this cycle
    function automatic logic idx_hit(input reg_idx_t rd_idx, input reg_idx_t wr_idx,
                                     input logic wr_en);
        return wr_en && (rd_idx == wr_idx);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - write-back and dual read-port bundle of the register file
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] IN;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic                  WRITEENABLE;
    logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;

    modport master (
        output IN, INADDRESS, WRITEENABLE, OUT1ADDRESS, OUT2ADDRESS,
        input  OUT1, OUT2
    );

    modport slave (
        input  IN, INADDRESS, WRITEENABLE, OUT1ADDRESS, OUT2ADDRESS,
        output OUT1, OUT2
    );

endinterface

// File: rtl/reg_file_read_port.sv
// rtl/reg_file_read_port.sv - one combinational read port with optional write bypass
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int BYPASS     = 0
) (
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
    input  logic                                       wr_en,
    input  logic [ADDR_WIDTH-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                      wr_data,
    output logic [DATA_WIDTH-1:0]                      rd_data
);

    // Select the stored word, overriding with in-flight write data when bypass is built in
    always_comb begin
        rd_data = regs[rd_addr];
        if ((BYPASS != 0) && wr_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x8 register file, synchronous write, two combinational read ports
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH,
    parameter int BYPASS     = 0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    reg_file_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic                             wr_armed;
    logic                             wr_fire;
    logic [DATA_WIDTH-1:0]            out1;
    logic [DATA_WIDTH-1:0]            out2;

    // Arm writes on the falling edge after reset release, so a release that lands
    // on (or races) a rising edge never lets that edge write.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_armed <= 1'b0;
        end else begin
            wr_armed <= 1'b1;
        end
    end

    // Also gates bypass so outputs stay 0 while reset is held or writes are disarmed
    assign wr_fire = bus.WRITEENABLE && wr_armed && RESET_N;

    // Storage array: async clear, write-back on rising edge when armed
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[bus.INADDRESS] <= bus.IN;
        end
    end

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_port1 (
        .regs    (regs),
        .rd_addr (bus.OUT1ADDRESS),
        .wr_en   (wr_fire),
        .wr_addr (bus.INADDRESS),
        .wr_data (bus.IN),
        .rd_data (out1)
    );

    reg_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_port2 (
        .regs    (regs),
        .rd_addr (bus.OUT2ADDRESS),
        .wr_en   (wr_fire),
        .wr_addr (bus.INADDRESS),
        .wr_data (bus.IN),
        .rd_data (out2)
    );

    assign bus.OUT1 = out1;
    assign bus.OUT2 = out2;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file, with and without bypass
module tb_reg_file;
    import reg_file_pkg::*;

    logic CLK;
    logic RESET_N;
    int   tests;
    int   fails;

    reg_file_if bus0 ();
    reg_file_if bus1 ();

    // Both instances see identical stimulus
    assign bus1.IN          = bus0.IN;
    assign bus1.INADDRESS   = bus0.INADDRESS;
    assign bus1.WRITEENABLE = bus0.WRITEENABLE;
    assign bus1.OUT1ADDRESS = bus0.OUT1ADDRESS;
    assign bus1.OUT2ADDRESS = bus0.OUT2ADDRESS;

    reg_file #(.BYPASS(0)) dut0 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus0.slave));
    reg_file #(.BYPASS(1)) dut1 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus1.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic drive_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bus0.IN          = data;
        bus0.INADDRESS   = addr;
        bus0.WRITEENABLE = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge CLK);
        bus0.WRITEENABLE = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RESET_N          = 1'b0;
        bus0.IN          = 8'hEE;
        bus0.INADDRESS   = 3'd0;
        bus0.WRITEENABLE = 1'b1;
        bus0.OUT1ADDRESS = 3'd0;
        bus0.OUT2ADDRESS = 3'd0;

        // Held reset: outputs zero even with a matching write presented to the bypass build
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_out1_nobyp", bus0.OUT1, 8'h00);
        chk("rst_hold_out1_byp",   bus1.OUT1, 8'h00);
        chk("rst_hold_out2_byp",   bus1.OUT2, 8'h00);
        bus0.WRITEENABLE = 1'b0;

        // Release in the high phase; the next rising edge may write
        @(posedge CLK);
        #2 RESET_N = 1'b1;

        // Write R3 then pulse reset between edges
        drive_write(3'd3, 8'h5A);
        go_idle();
        bus0.OUT1ADDRESS = 3'd3;
        #1;
        chk("r3_written", bus0.OUT1, 8'h5A);
        @(negedge CLK);
        #1 RESET_N = 1'b0;
        #1;
        chk("async_rst_r3_immediate", bus0.OUT1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            bus0.OUT1ADDRESS = i[2:0];
            bus0.OUT2ADDRESS = 3'(7 - i);
            #1;
            chk($sformatf("rst_all_out1_r%0d", i), bus0.OUT1, 8'h00);
            chk($sformatf("rst_all_out2_r%0d", 7 - i), bus1.OUT2, 8'h00);
        end
        @(posedge CLK);
        #2 RESET_N = 1'b1;

        // Consecutive writes, dual read
        drive_write(3'd1, 8'h0F);
        drive_write(3'd2, 8'hF1);
        go_idle();
        bus0.OUT1ADDRESS = 3'd1;
        bus0.OUT2ADDRESS = 3'd2;
        #1;
        chk("dual_read_out1", bus0.OUT1, 8'h0F);
        chk("dual_read_out2", bus0.OUT2, 8'hF1);
        chk("dual_read_out1_byp", bus1.OUT1, 8'h0F);
        chk("dual_read_out2_byp", bus1.OUT2, 8'hF1);

        // Both ports on one address
        bus0.OUT2ADDRESS = 3'd1;
        #1;
        chk("same_addr_out2", bus0.OUT2, 8'h0F);

        // Write-enable gating
        @(negedge CLK);
        bus0.IN          = 8'hAA;
        bus0.INADDRESS   = 3'd4;
        bus0.WRITEENABLE = 1'b0;
        bus0.OUT1ADDRESS = 3'd4;
        repeat (3) @(posedge CLK);
        #1;
        chk("we_low_r4", bus0.OUT1, 8'h00);
        chk("we_low_r4_byp", bus1.OUT1, 8'h00);
        drive_write(3'd4, 8'hAA);
        go_idle();
        #1;
        chk("we_high_r4", bus0.OUT1, 8'hAA);

        // Same-address read/write around the edge
        drive_write(3'd5, 8'h11);
        go_idle();
        @(negedge CLK);
        bus0.IN          = 8'h22;
        bus0.INADDRESS   = 3'd5;
        bus0.WRITEENABLE = 1'b1;
        bus0.OUT1ADDRESS = 3'd5;
        bus0.OUT2ADDRESS = 3'd5;
        #1;
        chk("nobyp_pre_out1", bus0.OUT1, 8'h11);
        chk("nobyp_pre_out2", bus0.OUT2, 8'h11);
        chk("byp_pre_out1",   bus1.OUT1, 8'h22);
        chk("byp_pre_out2",   bus1.OUT2, 8'h22);
        bus0.OUT2ADDRESS = 3'd4;
        #1;
        chk("byp_indep_out2_r4", bus1.OUT2, 8'hAA);
        chk("byp_indep_out1_r5", bus1.OUT1, 8'h22);
        @(posedge CLK);
        #1;
        bus0.WRITEENABLE = 1'b0;
        #1;
        chk("nobyp_post_out1", bus0.OUT1, 8'h22);
        chk("byp_post_out1",   bus1.OUT1, 8'h22);

        // Reset colliding with a write, then release coincident with an edge
        @(negedge CLK);
        bus0.IN          = 8'h77;
        bus0.INADDRESS   = 3'd6;
        bus0.WRITEENABLE = 1'b1;
        bus0.OUT1ADDRESS = 3'd6;
        #4 RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_vs_write_r6", bus0.OUT1, 8'h00);
        chk("rst_vs_write_r6_byp", bus1.OUT1, 8'h00);
        @(posedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("release_edge_r6", bus0.OUT1, 8'h00);
        chk("release_edge_r6_byp", bus1.OUT1, 8'h00);
        @(posedge CLK);
        #1;
        chk("first_write_after_release", bus0.OUT1, 8'h77);
        chk("first_write_after_release_byp", bus1.OUT1, 8'h77);
        bus0.WRITEENABLE = 1'b0;
        #1;
        chk("r5_kept_through_nothing", bus0.OUT2, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
